// File: rtl/score_pkg.sv
// Shared types and seven-segment helpers for the Connect Four scoreboard.
// Patterns are active-low, bit6..bit0 = segments g..a.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY,
    WIN_G,
    WIN_R,
    DRAW
  } game_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Decimal digit to segment pattern; codes above 9 show nothing.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/score_hex_driver_banner_flasher.sv
// Banner flash timer: a half-period counter and the phase bit it toggles.
// Optional SCORE_WIN_AUTOCLR_EN adds a toggle counter that raises hold_done
// combinationally in the cycle whose edge performs the WIN_HOLD-th toggle,
// so the owner can clear the game at that same edge.
module banner_flasher #(
  parameter int FLASH_HALF = 25_000_000,
  parameter int WIN_HOLD   = 6
) (
  input  logic clk,
  input  logic RST,
  input  logic run,
  input  logic restart,
  output logic phase,
  output logic hold_done
);

  localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] flash_cnt;
  logic          wrap;

  assign wrap = run && (flash_cnt == LAST);

  // Half-period counter; idles at 0 with phase high whenever not running.
  always_ff @(posedge clk) begin
    if (RST || restart || !run) begin
      flash_cnt <= '0;
      phase     <= 1'b1;
    end else if (wrap) begin
      flash_cnt <= '0;
      phase     <= ~phase;
    end else begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

`ifdef SCORE_WIN_AUTOCLR_EN
  localparam int TW = (WIN_HOLD > 0) ? $clog2(WIN_HOLD + 1) : 1;

  logic [TW-1:0] tog_cnt;

  // Counts phase toggles since the win state was entered.
  always_ff @(posedge clk) begin
    if (RST || restart || !run) begin
      tog_cnt <= '0;
    end else if (wrap) begin
      tog_cnt <= tog_cnt + 1'b1;
    end
  end

  assign hold_done = wrap && (tog_cnt == TW'(WIN_HOLD - 1));
`else
  assign hold_done = 1'b0;
`endif

endmodule

// File: rtl/score_hex_driver.sv
// Two-player scoreboard: score counters, win FSM and registered HEX drivers.
// HEX3/HEX2 show green/red scores; HEX5/HEX4 and HEX1/HEX0 flash "P1"/"P2".
// Build option: SCORE_WIN_AUTOCLR_EN returns to PLAY after WIN_HOLD toggles.
module score_hex_driver
  import score_pkg::*;
#(
  parameter int WIN_SCORE  = 5,
  parameter int FLASH_HALF = 25_000_000,
  parameter int WIN_HOLD   = 6
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       incG,
  input  logic       incR,
  input  logic       newGame,
  output logic [3:0] scoreG,
  output logic [3:0] scoreR,
  output logic       winG,
  output logic       winR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam logic [3:0] WIN_V = 4'(WIN_SCORE);

  game_state_t state_q, state_d;
  logic [3:0]  nxt_g, nxt_r;
  logic        clear, restart, run, phase, hold_done;

  // An auto-clear behaves exactly like a newGame pulse at the same edge.
  assign clear   = newGame || hold_done;
  assign run     = (state_q != PLAY);
  assign restart = clear || ((state_q == PLAY) && (state_d != PLAY));

  banner_flasher #(
    .FLASH_HALF(FLASH_HALF),
    .WIN_HOLD  (WIN_HOLD)
  ) u_flash (
    .clk      (clk),
    .RST      (RST),
    .run      (run),
    .restart  (restart),
    .phase    (phase),
    .hold_done(hold_done)
  );

  // State and score registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= PLAY;
      scoreG  <= '0;
      scoreR  <= '0;
    end else begin
      state_q <= state_d;
      scoreG  <= nxt_g;
      scoreR  <= nxt_r;
    end
  end

  // Next scores and next state; win detection uses the post-increment scores.
  always_comb begin
    nxt_g   = scoreG;
    nxt_r   = scoreR;
    state_d = state_q;
    if (clear) begin
      nxt_g   = '0;
      nxt_r   = '0;
      state_d = PLAY;
    end else if (state_q == PLAY) begin
      if (incG && (scoreG < WIN_V)) nxt_g = scoreG + 4'd1;
      if (incR && (scoreR < WIN_V)) nxt_r = scoreR + 4'd1;
      if ((nxt_g == WIN_V) && (nxt_r == WIN_V)) state_d = DRAW;
      else if (nxt_g == WIN_V)                  state_d = WIN_G;
      else if (nxt_r == WIN_V)                  state_d = WIN_R;
    end
  end

  // Winner flags decoded from the state register.
  always_comb begin
    winG = (state_q == WIN_G) || (state_q == DRAW);
    winR = (state_q == WIN_R) || (state_q == DRAW);
  end

  // Display registers, one cycle behind scores and flags.
  always_ff @(posedge clk) begin
    if (RST) begin
      HEX3 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX5 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX0 <= SEG_BLANK;
    end else begin
      HEX3 <= seg_digit(scoreG);
      HEX2 <= seg_digit(scoreR);
      HEX5 <= (winG && phase) ? SEG_P   : SEG_BLANK;
      HEX4 <= (winG && phase) ? SEG_ONE : SEG_BLANK;
      HEX1 <= (winR && phase) ? SEG_P   : SEG_BLANK;
      HEX0 <= (winR && phase) ? SEG_TWO : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_score_hex_driver.sv
// Bench for score_hex_driver with WIN_SCORE=3, FLASH_HALF=4, WIN_HOLD=2.
module tb_score_hex_driver;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] PP = 7'b0001100;

  typedef struct {
    logic       rst, g, r, n;
    logic [3:0] sg, sr;
    logic       wg, wr;
    logic [6:0] h3, h2;
    logic       bg, br;
  } vec_t;

  logic       clk = 1'b0;
  logic       RST = 1'b0, incG = 1'b0, incR = 1'b0, newGame = 1'b0;
  logic [3:0] scoreG, scoreR;
  logic       winG, winR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl[30];

  score_hex_driver #(
    .WIN_SCORE (3),
    .FLASH_HALF(4),
    .WIN_HOLD  (2)
  ) dut (
    .clk(clk), .RST(RST), .incG(incG), .incR(incR), .newGame(newGame),
    .scoreG(scoreG), .scoreR(scoreR), .winG(winG), .winR(winR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rst, g, r, n, input logic [3:0] sg, sr,
                              input logic wg, wr, input logic [6:0] h3, h2,
                              input logic bg, br);
    vec_t v;
    v.rst = rst; v.g = g; v.r = r; v.n = n;
    v.sg = sg; v.sr = sr; v.wg = wg; v.wr = wr;
    v.h3 = h3; v.h2 = h2; v.bg = bg; v.br = br;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    RST = v.rst; incG = v.g; incR = v.r; newGame = v.n;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".scoreG"}, {4'd0, scoreG}, {4'd0, e.sg});
    chk({tag, ".scoreR"}, {4'd0, scoreR}, {4'd0, e.sr});
    chk({tag, ".winG"}, {7'd0, winG}, {7'd0, e.wg});
    chk({tag, ".winR"}, {7'd0, winR}, {7'd0, e.wr});
    chk({tag, ".HEX3"}, {1'b0, HEX3}, {1'b0, e.h3});
    chk({tag, ".HEX2"}, {1'b0, HEX2}, {1'b0, e.h2});
    chk({tag, ".HEX5"}, {1'b0, HEX5}, {1'b0, e.bg ? PP : BL});
    chk({tag, ".HEX4"}, {1'b0, HEX4}, {1'b0, e.bg ? D1 : BL});
    chk({tag, ".HEX1"}, {1'b0, HEX1}, {1'b0, e.br ? PP : BL});
    chk({tag, ".HEX0"}, {1'b0, HEX0}, {1'b0, e.br ? D2 : BL});
  endtask

  task automatic reach_win_g(input string tag);
    apply(mk(0, 1, 0, 0, 1, 0, 0, 0, D0, D0, 0, 0), {tag, ".g1"});
    apply(mk(0, 1, 0, 0, 2, 0, 0, 0, D1, D0, 0, 0), {tag, ".g2"});
    apply(mk(0, 1, 0, 0, 3, 0, 1, 0, D2, D0, 0, 0), {tag, ".g3"});
  endtask

  initial begin
    //            rst g r n  sg sr wg wr h3  h2  bg br
    tbl[0]  = mk(0, 1, 0, 0, 1, 0, 0, 0, D0, D0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 2, 0, 0, 0, D1, D0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 3, 0, 1, 0, D2, D0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 1, 0, 0, 0, 0, D3, D0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0);
    tbl[10] = mk(0, 1, 1, 0, 1, 1, 0, 0, D0, D0, 0, 0);
    tbl[11] = mk(0, 1, 1, 0, 2, 2, 0, 0, D1, D1, 0, 0);
    tbl[12] = mk(0, 1, 1, 0, 3, 3, 1, 1, D2, D2, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 3, 3, 1, 1, D3, D3, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 3, 3, 1, 1, D3, D3, 1, 1);
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 0, 0, D3, D3, 1, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 1, 0, 0, D0, D0, 0, 0);
    tbl[18] = mk(0, 0, 1, 0, 0, 2, 0, 0, D0, D1, 0, 0);
    tbl[19] = mk(0, 0, 1, 0, 0, 3, 0, 1, D0, D2, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 0, 3, 0, 1, D0, D3, 0, 1);
    tbl[21] = mk(0, 0, 1, 1, 0, 0, 0, 0, D0, D3, 0, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0);
    tbl[23] = mk(0, 1, 1, 0, 1, 1, 0, 0, D0, D0, 0, 0);
    tbl[24] = mk(0, 1, 0, 0, 2, 1, 0, 0, D1, D1, 0, 0);
    tbl[25] = mk(0, 1, 1, 0, 3, 2, 1, 0, D2, D1, 0, 0);
    tbl[26] = mk(0, 0, 0, 1, 0, 0, 0, 0, D3, D2, 1, 0);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0);
    tbl[28] = mk(0, 1, 0, 0, 1, 0, 0, 0, D0, D0, 0, 0);
    tbl[29] = mk(1, 1, 0, 1, 0, 0, 0, 0, D0, D0, 0, 0);

    // Reset followed by idle cycles.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0), "reset");
    for (int i = 0; i < 5; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0), $sformatf("idle%0d", i));

    // Vector table.
    for (int i = 0; i < 30; i++)
      apply(tbl[i], $sformatf("row%0d", i));

    // Banner timing after a green win.
    reach_win_g("flash");
`ifdef SCORE_WIN_AUTOCLR_EN
    for (int i = 1; i <= 9; i++) begin
      if (i < 8)
        apply(mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, (((i - 1) / 4) % 2) == 0, 0),
              $sformatf("autoclr%0d", i));
      else if (i == 8)
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, D3, D0, 0, 0), "autoclr8");
      else
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0), "autoclr9");
    end
`else
    for (int i = 0; i < 100; i++)
      apply(mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, ((i / 4) % 2) == 0, 0),
            $sformatf("hold%0d", i));
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, D3, D0, 0, 0), "hold.new");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0), "hold.idle");
`endif

    // Reset in the middle of a visible banner.
    reach_win_g("rstflash");
    apply(mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, 1, 0), "rstflash.v0");
    apply(mk(0, 0, 0, 0, 3, 0, 1, 0, D3, D0, 1, 0), "rstflash.v1");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0), "rstflash.rst");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, D0, D0, 0, 0), $sformatf("rstflash.after%0d", i));

    @(negedge clk);
    RST = 1'b0; incG = 1'b0; incR = 1'b0; newGame = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
